// File: rtl/uart_pkg.sv
// Shared constants for the Wishbone UART transmitter: register map,
// STATUS bit positions and serializer state encoding.
package uart_pkg;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting for the serializer.
// Head entry is visible combinationally so it can be popped and used on one edge.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign rdata = mem[rd_ptr_reg];

    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_wb.sv
// Wishbone-attached 8N1 UART transmitter: DATA register feeds a TX FIFO,
// STATUS reports FIFO level, busy and a sticky overflow flag.
module uart_tx_wb
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_wb_adr,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_tx,
    output logic        o_busy
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic        ack_reg;
    logic [31:0] rdt_reg;
    logic        ovf_reg;
    logic [1:0]  state_reg;
    logic [15:0] baud_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        tx_reg;

    logic          bus_req;
    logic          data_wr;
    logic          stat_clr;
    logic          stat_rd;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic          baud_end;
    logic [31:0]   status_word;
    logic          unused_ok;

    // A request is only taken when no ack is outstanding, giving one ack every other cycle.
    assign bus_req  = i_wb_cyc && !ack_reg;
    assign data_wr  = bus_req && i_wb_we && (i_wb_adr == REG_DATA) && i_wb_sel[0];
    assign stat_clr = bus_req && i_wb_we && (i_wb_adr == REG_STATUS) && i_wb_sel[0] && i_wb_dat[3];
    assign stat_rd  = bus_req && !i_wb_we && (i_wb_adr == REG_STATUS);
    assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;
    assign busy     = (state_reg != ST_IDLE) || !fifo_empty;
    assign baud_end = (baud_reg == BAUD_LAST);
    assign unused_ok = ^{i_wb_sel[3:1], i_wb_dat[31:8]};

    always_comb begin
        status_word = '0;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_BUSY]  = busy;
        status_word[STAT_OVF]   = ovf_reg;
        status_word[STAT_CNT_LSB +: CW] = fifo_count;
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (i_wb_clk),
        .rst   (i_wb_rst),
        .push  (data_wr),
        .pop   (fifo_pop),
        .wdata (i_wb_dat[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            ack_reg <= 1'b0;
            rdt_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            ack_reg <= bus_req;
            rdt_reg <= stat_rd ? status_word : 32'h0;
            if (stat_clr) begin
                ovf_reg <= 1'b0;
            end else if (data_wr && fifo_full && !fifo_pop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg   <= 1'b1;
                    baud_reg <= '0;
                    if (fifo_pop) begin
                        shift_reg <= fifo_rdata;
                        state_reg <= ST_START;
                        tx_reg    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_reg    <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= ST_DATA;
                        tx_reg      <= shift_reg[0];
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            tx_reg      <= shift_reg[bit_idx_reg + 3'd1];
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: begin
                    if (baud_end) begin
                        baud_reg  <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_wb_ack = ack_reg;
    assign o_wb_rdt = rdt_reg;
    assign o_tx     = tx_reg;
    assign o_busy   = busy;

endmodule
